// File: rtl/rd_req_rob_alloc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rd_req_rob_alloc_if
// Purpose  : Bundles the request, output-FIFO and release signals of one
//            read-xbar output lane's ROB id allocator.
//            master : upstream crossbar / downstream tag pipe / return path
//            slave  : the allocator (rd_req_rob_alloc)
// Signals  : in_vld/in_pld/in_rdy       request handshake
//            out_vld/out_pld/out_rob_id/out_rdy   output FIFO head
//            rls_vld/rls_id             id release strobe
//            free_cnt, err_dbl_free     status
// Revision : 1.0  initial release
// ============================================================================
interface rd_req_rob_alloc_if #(
    parameter int PLD_WIDTH = 32,
    parameter int ROB_ID_W  = 5
);
    logic                 in_vld;
    logic [PLD_WIDTH-1:0] in_pld;
    logic                 in_rdy;
    logic                 out_vld;
    logic [PLD_WIDTH-1:0] out_pld;
    logic [ROB_ID_W-1:0]  out_rob_id;
    logic                 out_rdy;
    logic                 rls_vld;
    logic [ROB_ID_W-1:0]  rls_id;
    logic [ROB_ID_W:0]    free_cnt;
    logic                 err_dbl_free;

    modport master (
        output in_vld, in_pld, out_rdy, rls_vld, rls_id,
        input  in_rdy, out_vld, out_pld, out_rob_id, free_cnt, err_dbl_free
    );

    modport slave (
        input  in_vld, in_pld, out_rdy, rls_vld, rls_id,
        output in_rdy, out_vld, out_pld, out_rob_id, free_cnt, err_dbl_free
    );
endinterface
`default_nettype wire

// File: rtl/rd_req_rob_alloc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rd_req_rob_alloc
// Purpose  : Allocates the lowest free ROB entry id to each accepted read
//            request, queues payload+id in a 2-entry in-order FIFO and
//            returns ids to the free pool on release.
// Ports    : clk, rst (sync, active high)
//            bus (rd_req_rob_alloc_if.slave): request in, FIFO head out,
//            release strobe, free_cnt and sticky double-free flag.
// Revision : 1.0  initial release
// ============================================================================
module rd_req_rob_alloc #(
    parameter int PLD_WIDTH = 32,
    parameter int ROB_DEPTH = 32,
    parameter int ROB_ID_W  = $clog2(ROB_DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rd_req_rob_alloc_if.slave bus
);

    localparam logic [ROB_ID_W:0] c_CNT_ONE  = (ROB_ID_W+1)'(1);
    localparam logic [ROB_ID_W:0] c_CNT_FULL = (ROB_ID_W+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] r_free_vec;
    logic [ROB_ID_W:0]    r_free_cnt;
    logic                 r_err_dbl_free;
    logic [PLD_WIDTH-1:0] r_pld [2];
    logic [ROB_ID_W-1:0]  r_id  [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_fifo_cnt;

    logic                 w_in_rdy;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_rls_ok;
    logic                 w_rls_dbl;
    logic [ROB_ID_W-1:0]  w_alloc_id;
    logic [ROB_DEPTH-1:0] w_free_nxt;

    // Ready depends on registered state only; rst masks it so nothing is
    // accepted in the reset cycle.
    assign w_in_rdy  = !rst && (r_fifo_cnt != 2'd2) && (r_free_cnt != '0);
    assign w_accept  = bus.in_vld && w_in_rdy;
    assign w_pop     = (r_fifo_cnt != 2'd0) && bus.out_rdy;
    assign w_rls_ok  = bus.rls_vld && !r_free_vec[bus.rls_id];
    assign w_rls_dbl = bus.rls_vld &&  r_free_vec[bus.rls_id];

    // Lowest set bit of the current free vector; a same-cycle release is
    // not visible here, so a released id is only reusable next cycle.
    always_comb begin
        w_alloc_id = '0;
        for (int i = ROB_DEPTH-1; i >= 0; i--) begin
            if (r_free_vec[i]) begin
                w_alloc_id = ROB_ID_W'(i);
            end
        end
    end

    // The allocated bit is set and a valid release targets a clear bit, so
    // the two updates never touch the same position.
    always_comb begin
        w_free_nxt = r_free_vec;
        if (w_accept) begin
            w_free_nxt[w_alloc_id] = 1'b0;
        end
        if (w_rls_ok) begin
            w_free_nxt[bus.rls_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_free_vec     <= '1;
            r_free_cnt     <= c_CNT_FULL;
            r_err_dbl_free <= 1'b0;
            r_pld[0]       <= '0;
            r_pld[1]       <= '0;
            r_id[0]        <= '0;
            r_id[1]        <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            r_free_vec <= w_free_nxt;

            case ({w_accept, w_rls_ok})
                2'b10:   r_free_cnt <= r_free_cnt - c_CNT_ONE;
                2'b01:   r_free_cnt <= r_free_cnt + c_CNT_ONE;
                default: r_free_cnt <= r_free_cnt;
            endcase

            if (w_rls_dbl) begin
                r_err_dbl_free <= 1'b1;
            end

            if (w_accept) begin
                r_pld[r_wptr] <= bus.in_pld;
                r_id[r_wptr]  <= w_alloc_id;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end

            case ({w_accept, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign bus.in_rdy       = w_in_rdy;
    assign bus.out_vld      = (r_fifo_cnt != 2'd0);
    assign bus.out_pld      = r_pld[r_rptr];
    assign bus.out_rob_id   = r_id[r_rptr];
    assign bus.free_cnt     = r_free_cnt;
    assign bus.err_dbl_free = r_err_dbl_free;

endmodule
`default_nettype wire

// File: doc/rd_req_rob_alloc.md
Name: rd_req_rob_alloc

Overview:
- One instance per read-xbar output lane; sits directly downstream of the N-to-4 read request crossbar, one instance on each of its 4 output channels.
- Accepts arbitrated read requests and allocates a free reorder-buffer (ROB) entry id to each one, lowest free index first.
- Buffers each request with its id in a 2-entry output FIFO toward the tag pipeline.
- Returns ids to the free pool when the read-data return path releases them.

Parameters:
- PLD_WIDTH, default $bits(input_req_pld_t): request payload width, passed through unmodified.
- ROB_DEPTH, default 32: number of ROB entries this lane owns. Must be a power of 2 and at least 2.
- ROB_ID_W, default $clog2(ROB_DEPTH): width of an entry id.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  request valid from the crossbar output lane.
- in_pld  input  PLD_WIDTH  request payload.
- in_rdy  output  1  request accepted when in_vld and in_rdy are both high.
- out_vld  output  1  head of the output FIFO is valid.
- out_pld  output  PLD_WIDTH  head payload.
- out_rob_id  output  ROB_ID_W  ROB id allocated to the head payload.
- out_rdy  input  1  downstream accept.
- rls_vld  input  1  release strobe from the read-data return path.
- rls_id  input  ROB_ID_W  id being released.
- free_cnt  output  ROB_ID_W+1  number of free ids (registered).
- err_dbl_free  output  1  sticky flag: a release targeted an id that was already free.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - free_vec is all ones and free_cnt = ROB_DEPTH.
  - FIFO is empty: out_vld=0, out_pld=0, out_rob_id=0.
  - err_dbl_free=0.
  - Reset mid-operation discards in-flight FIFO contents and frees every id. No release is needed afterwards.
- in_rdy:
  - in_rdy = (fifo_cnt < 2) && (free_cnt != 0), driven from registered state only.
  - There is no combinational path from out_rdy or rls_vld to in_rdy.
  - in_rdy is 0 during the reset cycle.
- Allocation on accept:
  - The allocated id is the lowest set bit of free_vec as of the current cycle, before any same-cycle release.
  - That bit clears at the edge. The payload and id are written to the FIFO tail.
- Latency: a request accepted at edge T is presented on out_vld/out_pld/out_rob_id from T+1.
- FIFO:
  - 2 entries, in-order.
  - Pop when out_vld && out_rdy. Push and pop in the same cycle leave fifo_cnt unchanged.
  - out_pld and out_rob_id hold stable while out_vld && !out_rdy.
- Release:
  - When rls_vld is high and free_vec[rls_id]==0, the bit sets at the edge.
  - A released id is allocatable from the next cycle, never in the same cycle.
  - When rls_vld is high and free_vec[rls_id]==1, the release is ignored and err_dbl_free sets; it stays set until rst.
- free_cnt next value = free_cnt − accept + valid_release (each term 0 or 1). Simultaneous accept and valid release leave it unchanged. It never exceeds ROB_DEPTH or goes below 0.
- Full pool (free_cnt==0): in_rdy=0. A release in cycle T allows in_rdy=1 in cycle T+1.
- Payload handling: in_pld is never inspected or modified. The rob_entry_id field is stamped from out_rob_id by the consumer.
- Assertions:
  - in_pld is stable while in_vld && !in_rdy (upstream contract).
  - An id never appears twice on the output between releases.

Test Plan:
- Reset, then 3 back-to-back requests with out_rdy=1 → ids 0,1,2 appear on consecutive cycles, each 1 cycle after its accept; free_cnt reads 29 afterwards.
- ROB_DEPTH=4, out_rdy=1, 5 requests, no releases → ids 0–3 issued; in_rdy=0 once free_cnt=0; release id 2 at cycle T → in_rdy=1 at T+1 and the 5th request receives id 2.
- out_rdy=0, 3 requests → first two accepted, in_rdy=0 once fifo_cnt=2 (free_cnt still 30), out_pld/out_rob_id held stable; out_rdy=1 → ids 0,1 drain in order, then the 3rd is accepted with id 2.
- With ids 0 and 1 allocated, release id 0 and accept a request in the same cycle → new request gets id 2 (not 0); free_cnt unchanged.
- Release id 5 while it is already free → err_dbl_free=1 from the next cycle, free_cnt unchanged; it clears only on rst.
- Assert rst with 2 entries in the FIFO and 10 ids allocated → next cycle out_vld=0, free_cnt=32, in_rdy=1 one cycle after rst deasserts, next allocation returns id 0.
